// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter byte port among NUM_REQ
// producers; a grant is held for a whole message (until last or the burst cap).
module uart_tx_arbiter #(
  parameter int NUM_REQ   = 4,
  parameter int DATA_BITS = 8,
  parameter int MAX_BURST = 16,
  localparam int PTR_W    = $clog2(NUM_REQ),
  localparam int BEATS_W  = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1
) (
  input  logic                           i_clk,
  input  logic                           i_rst_n,
  input  logic [NUM_REQ*DATA_BITS-1:0]   i_req_data,
  input  logic [NUM_REQ-1:0]             i_req_valid,
  input  logic [NUM_REQ-1:0]             i_req_last,
  output logic [NUM_REQ-1:0]             o_req_ready,
  output logic [DATA_BITS-1:0]           o_tx_data,
  output logic                           o_tx_valid,
  input  logic                           i_tx_ready,
  output logic [NUM_REQ-1:0]             o_grant,
  output logic                           o_busy,
  output logic                           o_dbg_state,
  output logic [PTR_W-1:0]               o_dbg_ptr,
  output logic [BEATS_W-1:0]             o_dbg_beats
);

  // Handshake: a byte moves on any cycle where valid and ready are both high;
  // valid never waits on ready, and the producer holds data/last until accepted.

  typedef enum logic {S_IDLE = 1'b0, S_OWNED = 1'b1} state_t;

  localparam logic [PTR_W:0]     NUM_REQ_W = (PTR_W+1)'(NUM_REQ);
  localparam logic [PTR_W-1:0]   LAST_IDX  = PTR_W'(NUM_REQ - 1);
  localparam logic [BEATS_W-1:0] BEAT_CAP  = BEATS_W'(MAX_BURST - 1);

  state_t               r_state;
  logic [NUM_REQ-1:0]   r_grant;
  logic [PTR_W-1:0]     r_ptr;
  logic [BEATS_W-1:0]   r_beats;

  logic                 w_sel_valid;
  logic                 w_sel_last;
  logic [DATA_BITS-1:0] w_sel_data;
  logic [PTR_W-1:0]     w_own_idx;
  logic [PTR_W-1:0]     w_next_ptr;
  logic                 w_beat;

  logic [NUM_REQ-1:0]   w_rot;
  logic                 w_found;
  logic [PTR_W-1:0]     w_off;
  logic [PTR_W:0]       w_sum;
  logic [PTR_W-1:0]     w_win_idx;
  logic [NUM_REQ-1:0]   w_win_oh;

  // Mux the owner's stream onto the transmitter; grant is all-zero when idle.
  always_comb begin
    w_sel_valid = 1'b0;
    w_sel_last  = 1'b0;
    w_sel_data  = '0;
    w_own_idx   = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (r_grant[i]) begin
        w_sel_valid = i_req_valid[i];
        w_sel_last  = i_req_last[i];
        w_sel_data  = i_req_data[i*DATA_BITS +: DATA_BITS];
        w_own_idx   = PTR_W'(i);
      end
    end
  end

  assign w_beat     = w_sel_valid & i_tx_ready;
  assign w_next_ptr = (w_own_idx == LAST_IDX) ? '0 : w_own_idx + 1'b1;

  // Rotate requests so index 0 is the priority holder, then pick the lowest set bit.
  assign w_rot = NUM_REQ'({i_req_valid, i_req_valid} >> r_ptr);

  always_comb begin
    w_found = |w_rot;
    w_off   = '0;
    for (int j = NUM_REQ - 1; j >= 0; j--) begin
      if (w_rot[j]) w_off = PTR_W'(j);
    end
  end

  assign w_sum     = {1'b0, r_ptr} + {1'b0, w_off};
  assign w_win_idx = (w_sum >= NUM_REQ_W) ? PTR_W'(w_sum - NUM_REQ_W) : PTR_W'(w_sum);
  assign w_win_oh  = {{(NUM_REQ-1){1'b0}}, 1'b1} << w_win_idx;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= S_IDLE;
      r_grant <= '0;
      r_ptr   <= '0;
      r_beats <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_found) begin
            r_grant <= w_win_oh;
            r_beats <= '0;
            r_state <= S_OWNED;
          end
        end
        S_OWNED: begin
          if (w_beat) begin
            // The cap releases without faking last; the producer resumes later.
            if (w_sel_last || (r_beats == BEAT_CAP)) begin
              r_grant <= '0;
              r_ptr   <= w_next_ptr;
              r_state <= S_IDLE;
            end else begin
              r_beats <= r_beats + 1'b1;
            end
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_grant <= '0;
        end
      endcase
    end
  end

  assign o_tx_valid  = w_sel_valid;
  assign o_tx_data   = w_sel_data;
  assign o_req_ready = r_grant & {NUM_REQ{i_tx_ready}};
  assign o_grant     = r_grant;
  assign o_busy      = (r_state == S_OWNED);
  assign o_dbg_state = (r_state == S_OWNED);
  assign o_dbg_ptr   = r_ptr;
  assign o_dbg_beats = r_beats;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: per-cycle reference model, expected byte queue,
// and directed scenarios with hand-computed byte orders and timings.
module tb_uart_tx_arbiter;

  localparam int NR = 4;
  localparam int DW = 8;
  localparam int MB = 4;
  localparam int SW = NR + DW;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [NR*DW-1:0] req_data;
  logic [NR-1:0]    req_valid;
  logic [NR-1:0]    req_last;
  logic [NR-1:0]    req_ready;
  logic [DW-1:0]    tx_data;
  logic             tx_valid;
  logic             tx_ready;
  logic [NR-1:0]    grant;
  logic             busy;
  logic             dbg_state;
  logic [1:0]       dbg_ptr;
  logic [1:0]       dbg_beats;

  uart_tx_arbiter #(.NUM_REQ(NR), .DATA_BITS(DW), .MAX_BURST(MB)) dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_req_data(req_data), .i_req_valid(req_valid), .i_req_last(req_last),
    .o_req_ready(req_ready), .o_tx_data(tx_data), .o_tx_valid(tx_valid),
    .i_tx_ready(tx_ready), .o_grant(grant), .o_busy(busy),
    .o_dbg_state(dbg_state), .o_dbg_ptr(dbg_ptr), .o_dbg_beats(dbg_beats)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- producer queues and driver ----------------
  logic [8:0]     src_mem [NR][32];
  int             src_head [NR];
  int             src_tail [NR];
  logic           rdy_q[$];
  logic [SW-1:0]  exp_q[$];
  logic [NR-1:0]  acc = '0;
  logic           rst_at_edge;

  task automatic push_src(int r, logic [7:0] d, logic l);
    src_mem[r][src_tail[r]] = {l, d};
    src_tail[r]++;
  endtask

  task automatic push_exp(int r, logic [7:0] d);
    logic [NR-1:0] oh;
    oh = '0;
    oh[r] = 1'b1;
    exp_q.push_back({oh, d});
  endtask

  function automatic logic src_pending();
    logic p;
    p = 1'b0;
    for (int i = 0; i < NR; i++) if (src_tail[i] != src_head[i]) p = 1'b1;
    return p;
  endfunction

  initial begin
    for (int i = 0; i < NR; i++) begin
      src_head[i] = 0;
      src_tail[i] = 0;
    end
    req_valid = '0;
    req_last  = '0;
    req_data  = '0;
    tx_ready  = 1'b1;
    forever begin
      @(posedge clk);
      rst_at_edge = rst_n;
      #1;
      for (int i = 0; i < NR; i++) begin
        if (rst_at_edge && acc[i] && (src_tail[i] != src_head[i])) src_head[i]++;
        if (src_tail[i] != src_head[i]) begin
          req_valid[i]            = 1'b1;
          req_last[i]             = src_mem[i][src_head[i]][8];
          req_data[i*DW +: DW]    = src_mem[i][src_head[i]][7:0];
        end else begin
          req_valid[i]            = 1'b0;
          req_last[i]             = 1'b0;
          req_data[i*DW +: DW]    = 8'($urandom_range(0, 255));
        end
      end
      if (rdy_q.size() > 0) tx_ready = rdy_q.pop_front();
      else                  tx_ready = 1'b1;
    end
  end

  // ---------------- reference model + compare (one process) ----------------
  int             m_own   = -1;
  int             m_ptr   = 0;
  int             m_beats = 0;
  logic [NR-1:0]  e_grant;
  logic [NR-1:0]  e_ready;
  logic           e_valid;
  logic [SW-1:0]  e_sb;
  int             pick;

  always @(negedge clk) begin
    if (!rst_n) begin
      check("rst_grant", grant, 0);
      check("rst_busy", busy, 0);
      check("rst_tx_valid", tx_valid, 0);
      check("rst_req_ready", req_ready, 0);
      check("rst_ptr", dbg_ptr, 0);
      m_own = -1; m_ptr = 0; m_beats = 0;
      acc = '0;
    end else begin
      e_grant = '0;
      if (m_own >= 0) e_grant[m_own] = 1'b1;
      e_valid = (m_own >= 0) && req_valid[m_own];
      e_ready = tx_ready ? e_grant : '0;
      check("grant", grant, e_grant);
      check("busy", busy, m_own >= 0);
      check("state", dbg_state, m_own >= 0);
      check("tx_valid", tx_valid, e_valid);
      check("req_ready", req_ready, e_ready);
      check("ptr", dbg_ptr, m_ptr);
      if (m_own >= 0) begin
        check("beats", dbg_beats, m_beats);
        if (e_valid) check("tx_data", tx_data, req_data[m_own*DW +: DW]);
      end
      // scoreboard of the accepted byte stream, tagged with its owner
      if (tx_valid && tx_ready) begin
        if (exp_q.size() == 0) begin
          n_tests++; n_fail++;
          $display("FAIL unexpected_beat: got grant=0x%0h data=0x%0h expected none (t=%0t)", grant, tx_data, $time);
        end else begin
          e_sb = exp_q.pop_front();
          check("sb_byte", {grant, tx_data}, e_sb);
        end
      end
      acc = req_ready & req_valid;
      // advance the model to the next cycle
      if (m_own < 0) begin
        pick = -1;
        for (int k = 0; k < NR; k++)
          if (pick < 0 && req_valid[(m_ptr + k) % NR]) pick = (m_ptr + k) % NR;
        if (pick >= 0) begin
          m_own = pick;
          m_beats = 0;
        end
      end else if (req_valid[m_own] && tx_ready) begin
        if (req_last[m_own] || m_beats == MB - 1) begin
          m_ptr = (m_own + 1) % NR;
          m_own = -1;
        end else begin
          m_beats++;
        end
      end
    end
  end

  // ---------------- helpers ----------------
  task automatic do_reset();
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check("rst_async_tx_valid", tx_valid, 0);
    check("rst_async_grant", grant, 0);
    check("rst_async_busy", busy, 0);
    check("rst_async_req_ready", req_ready, 0);
    for (int i = 0; i < NR; i++) begin
      src_head[i] = 0;
      src_tail[i] = 0;
    end
    exp_q.delete();
    rdy_q.delete();
    repeat (2) @(posedge clk);
    #3;
    rst_n = 1'b1;
  endtask

  task automatic wait_drain(string name);
    int n;
    n = 0;
    do begin
      @(posedge clk);
      #2;
      n++;
    end while ((exp_q.size() != 0 || busy || src_pending()) && n < 300);
    check({name, "_timeout"}, n < 300, 1);
    check({name, "_drain"}, exp_q.size(), 0);
  endtask

  // ---------------- directed scenarios ----------------
  initial begin
    repeat (2) @(posedge clk);
    #3;
    rst_n = 1'b1;
    @(posedge clk);
    #2;
    check("reset_grant", grant, 0);
    check("reset_busy", busy, 0);
    check("reset_ptr", dbg_ptr, 0);

    // single 3-byte message from requester 2
    push_src(2, 8'h41, 1'b0); push_src(2, 8'h42, 1'b0); push_src(2, 8'h43, 1'b1);
    push_exp(2, 8'h41); push_exp(2, 8'h42); push_exp(2, 8'h43);
    @(posedge clk); #2;
    check("t1_idle_no_grant", grant, 0);
    check("t1_idle_no_valid", tx_valid, 0);
    @(posedge clk); #2;
    check("t1_grant", grant, 4'b0100);
    check("t1_first_byte", tx_data, 8'h41);
    repeat (3) @(posedge clk);
    #2;
    check("t1_release", grant, 0);
    check("t1_ptr", dbg_ptr, 3);
    wait_drain("t1");

    // simultaneous requesters 0 and 3
    do_reset();
    push_src(0, 8'h10, 1'b0); push_src(0, 8'h11, 1'b1);
    push_src(3, 8'h30, 1'b0); push_src(3, 8'h31, 1'b1);
    push_exp(0, 8'h10); push_exp(0, 8'h11); push_exp(3, 8'h30); push_exp(3, 8'h31);
    wait_drain("t2");
    check("t2_ptr_wrap", dbg_ptr, 0);

    // burst cap of 4 with requester 2 waiting
    do_reset();
    for (int k = 0; k < 6; k++) push_src(1, 8'(8'h50 + k), k == 5);
    push_src(2, 8'h60, 1'b0); push_src(2, 8'h61, 1'b1);
    for (int k = 0; k < 4; k++) push_exp(1, 8'(8'h50 + k));
    push_exp(2, 8'h60); push_exp(2, 8'h61);
    push_exp(1, 8'h54); push_exp(1, 8'h55);
    wait_drain("t3");

    // backpressure 1,0,0,1 during a message
    do_reset();
    for (int k = 0; k < 4; k++) push_src(0, 8'(8'h70 + k), k == 3);
    for (int k = 0; k < 4; k++) push_exp(0, 8'(8'h70 + k));
    rdy_q.push_back(1'b1); rdy_q.push_back(1'b1); rdy_q.push_back(1'b0);
    rdy_q.push_back(1'b0); rdy_q.push_back(1'b1);
    repeat (3) @(posedge clk);
    #2;
    for (int s = 0; s < 2; s++) begin
      check("t4_stall_data", tx_data, 8'h71);
      check("t4_stall_valid", tx_valid, 1);
      check("t4_stall_ready", req_ready, 0);
      check("t4_stall_grant", grant, 4'b0001);
      check("t4_stall_beats", dbg_beats, 1);
      @(posedge clk);
      #2;
    end
    wait_drain("t4");
    check("t4_ptr", dbg_ptr, 1);

    // reset after beat 2 of a 5-byte message; arbitration restarts from 0
    for (int k = 0; k < 5; k++) push_src(3, 8'(8'h80 + k), k == 4);
    push_exp(3, 8'h80); push_exp(3, 8'h81);
    repeat (3) @(posedge clk);
    do_reset();
    @(posedge clk);
    #2;
    push_src(0, 8'h90, 1'b1); push_src(3, 8'h93, 1'b1);
    push_exp(0, 8'h90); push_exp(3, 8'h93);
    wait_drain("t5");

    // fairness: all four continuously valid with 1-byte messages
    do_reset();
    for (int k = 0; k < 3; k++)
      for (int i = 0; i < NR; i++) push_src(i, 8'(16 * i + k), 1'b1);
    for (int k = 0; k < 3; k++)
      for (int i = 0; i < NR; i++) push_exp(i, 8'(16 * i + k));
    wait_drain("t6");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish before 200000");
    $fatal(1, "watchdog");
  end

endmodule
